// File: rtl/alu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit with a start/busy/done handshake.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU/REM/REMU complete as illegal.
module alu_muldiv #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_in_a,
    input  logic [XLEN-1:0] i_in_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal
);

    localparam int unsigned N    = XLEN / UNROLL;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StPrep, StCalc, StDone} state_e;

    state_e            r_state;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_op2;
    logic              r_neg;
    logic [CntW-1:0]   r_cnt;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_neg;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_res;
    logic [XLEN-1:0]   w_hi_n;
    logic [XLEN-1:0]   w_lo_n;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_final;

`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN:0]     w_shl;
    logic [XLEN:0]     w_diff;
    logic              w_b_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_qr;
    logic [XLEN-1:0]   w_qr_fix;
`else
    logic              r_illegal;
`endif

    // Signedness of each operand per funct3.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (r_funct3)
            3'b001, 3'b100, 3'b110: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'b010:  w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_a_sgn = w_a_signed & r_a[XLEN-1];
    assign w_b_sgn = w_b_signed & r_b[XLEN-1];
    assign w_a_abs = w_a_sgn ? -r_a : r_a;
    assign w_b_abs = w_b_sgn ? -r_b : r_b;
    // Remainder takes the dividend's sign; everything else the xor of both.
    assign w_neg   = (r_funct3[2] & r_funct3[1]) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);

`ifdef MULDIV_DIV_EN
    assign w_b_zero   = (r_b == '0);
    assign w_ovf      = ~r_funct3[0] & (r_a == MinVal) & (r_b == '1);
    assign w_special  = r_funct3[2] & (w_b_zero | w_ovf);
    assign w_spec_res = w_b_zero ? (r_funct3[1] ? r_a : '1)
                                 : (r_funct3[1] ? '0 : MinVal);
`else
    assign w_special  = r_funct3[2];
    assign w_spec_res = '0;
`endif

    // UNROLL iterations of shift-add (multiply) or restoring subtract (divide).
    // hi:lo holds partial product / remainder:quotient; r_op2 is multiplicand / divisor.
    always_comb begin
        w_hi_n = r_hi;
        w_lo_n = r_lo;
        w_sum  = '0;
`ifdef MULDIV_DIV_EN
        w_shl  = '0;
        w_diff = '0;
`endif
        for (int i = 0; i < int'(UNROLL); i++) begin
`ifdef MULDIV_DIV_EN
            if (r_funct3[2]) begin
                w_shl  = {w_hi_n, w_lo_n[XLEN-1]};
                w_diff = w_shl - {1'b0, r_op2};
                w_lo_n = {w_lo_n[XLEN-2:0], ~w_diff[XLEN]};
                w_hi_n = w_diff[XLEN] ? w_shl[XLEN-1:0] : w_diff[XLEN-1:0];
            end else
`endif
            begin
                w_sum  = {1'b0, w_hi_n} + {1'b0, {XLEN{w_lo_n[0]}} & r_op2};
                w_lo_n = {w_sum[0], w_lo_n[XLEN-1:1]};
                w_hi_n = w_sum[XLEN:1];
            end
        end
    end

    assign w_prod     = {w_hi_n, w_lo_n};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;

`ifdef MULDIV_DIV_EN
    assign w_qr     = r_funct3[1] ? w_hi_n : w_lo_n;
    assign w_qr_fix = r_neg ? -w_qr : w_qr;
    assign w_final  = r_funct3[2] ? w_qr_fix :
                      (r_funct3[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0]
                                               : w_prod_fix[2*XLEN-1:XLEN];
`else
    assign w_final  = (r_funct3[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0]
                                               : w_prod_fix[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_funct3 <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op2    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
`ifndef MULDIV_DIV_EN
            r_illegal <= 1'b0;
`endif
        end else if (i_kill) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifndef MULDIV_DIV_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_funct3 <= i_funct3;
                        r_a      <= i_in_a;
                        r_b      <= i_in_b;
                        r_busy   <= 1'b1;
                        r_state  <= StPrep;
                    end
                end
                StPrep: begin
                    r_hi  <= '0;
                    r_lo  <= w_a_abs;
                    r_op2 <= w_b_abs;
                    r_neg <= w_neg;
                    r_cnt <= CntW'(N - 1);
                    if (w_special) begin
                        r_result <= w_spec_res;
                        r_done   <= 1'b1;
`ifndef MULDIV_DIV_EN
                        r_illegal <= 1'b1;
`endif
                        r_state  <= StDone;
                    end else begin
                        r_state  <= StCalc;
                    end
                end
                StCalc: begin
                    r_hi <= w_hi_n;
                    r_lo <= w_lo_n;
                    if (r_cnt == '0) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
`ifndef MULDIV_DIV_EN
                    r_illegal <= 1'b0;
`endif
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
`ifdef MULDIV_DIV_EN
    assign o_illegal = 1'b0;
`else
    assign o_illegal = r_illegal;
`endif

endmodule
